// File: rtl/microwave_timer.sv
// Keypad-fed M:SS cook timer: synchronises encoder inputs, shifts digits in, counts down on 1 Hz ticks.
// Optional MICROWAVE_QUICK_START_EN: start at 0:00 loads 0:30, start while counting adds 30 s (sat 9:59).
module microwave_timer #(
  parameter int SYNC_STAGES = 2,
  parameter int DONE_TICKS  = 3
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       cook,
  output logic       done,
  output logic       zero
);

  localparam int CW = $clog2(DONE_TICKS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_PAUSE, ST_DONE} state_e;

  logic [SYNC_STAGES-1:0][3:0] d_sync_q;
  logic [SYNC_STAGES-1:0]      loadn_sync_q;
  logic [SYNC_STAGES-1:0]      pgt_sync_q;
  logic                        loadn_prev_q;
  logic                        pgt_prev_q;
  logic                        start_q;
  logic                        stop_q;

  state_e          state_q, state_d;
  logic [3:0]      min_ones_q, min_ones_d;
  logic [3:0]      sec_tens_q, sec_tens_d;
  logic [3:0]      sec_ones_q, sec_ones_d;
  logic [CW-1:0]   done_cnt_q, done_cnt_d;
  logic            cook_q, cook_d;
  logic            done_q, done_d;
  logic            zero_q, zero_d;

  logic       key_ev, tick, start_ev, stop_ev;
  logic [3:0] d_s;

  assign d_s      = d_sync_q[SYNC_STAGES-1];
  assign key_ev   = loadn_prev_q & ~loadn_sync_q[SYNC_STAGES-1];
  assign tick     = ~pgt_prev_q & pgt_sync_q[SYNC_STAGES-1];
  assign start_ev = start & ~start_q;
  assign stop_ev  = stop & ~stop_q;

`ifdef MICROWAVE_QUICK_START_EN
  // +30 s on M:SS; entered tens of 6..9 can overflow twice into minutes
  logic [4:0] t3;
  logic [3:0] add_tens;
  logic [4:0] add_min;

  always_comb begin
    t3       = {1'b0, sec_tens_q} + 5'd3;
    add_tens = t3[3:0];
    add_min  = {1'b0, min_ones_q};
    if (t3 >= 5'd12) begin
      add_tens = 4'(t3 - 5'd12);
      add_min  = {1'b0, min_ones_q} + 5'd2;
    end else if (t3 >= 5'd6) begin
      add_tens = 4'(t3 - 5'd6);
      add_min  = {1'b0, min_ones_q} + 5'd1;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    done_cnt_d = done_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (stop_ev) begin
          min_ones_d = 4'd0;
          sec_tens_d = 4'd0;
          sec_ones_d = 4'd0;
        end else if (start_ev && !zero_q) begin
          state_d = ST_COUNT;
`ifdef MICROWAVE_QUICK_START_EN
        end else if (start_ev) begin
          min_ones_d = 4'd0;
          sec_tens_d = 4'd3;
          sec_ones_d = 4'd0;
          state_d    = ST_COUNT;
`endif
        end else if (key_ev && (d_s <= 4'd9)) begin
          min_ones_d = sec_tens_q;
          sec_tens_d = sec_ones_q;
          sec_ones_d = d_s;
        end
      end

      ST_COUNT: begin
        if (stop_ev) begin
          state_d = ST_PAUSE;
`ifdef MICROWAVE_QUICK_START_EN
        end else if (start_ev) begin
          if (add_min > 5'd9) begin
            min_ones_d = 4'd9;
            sec_tens_d = 4'd5;
            sec_ones_d = 4'd9;
          end else begin
            min_ones_d = add_min[3:0];
            sec_tens_d = add_tens;
          end
`endif
        end else if (tick) begin
          if (sec_ones_q != 4'd0) begin
            sec_ones_d = sec_ones_q - 4'd1;
          end else begin
            sec_ones_d = 4'd9;
            if (sec_tens_q != 4'd0) begin
              sec_tens_d = sec_tens_q - 4'd1;
            end else begin
              sec_tens_d = 4'd5;
              min_ones_d = min_ones_q - 4'd1;
            end
          end
          if ({min_ones_d, sec_tens_d, sec_ones_d} == 12'd0) begin
            state_d    = ST_DONE;
            done_cnt_d = '0;
          end
        end
      end

      ST_PAUSE: begin
        if (stop_ev) begin
          min_ones_d = 4'd0;
          sec_tens_d = 4'd0;
          sec_ones_d = 4'd0;
          state_d    = ST_IDLE;
        end else if (start_ev) begin
          state_d = ST_COUNT;
        end
      end

      ST_DONE: begin
        if (stop_ev) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (done_cnt_q == CW'(DONE_TICKS - 1)) begin
            state_d    = ST_IDLE;
            done_cnt_d = '0;
          end else begin
            done_cnt_d = done_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    zero_d = ({min_ones_d, sec_tens_d, sec_ones_d} == 12'd0);
    cook_d = (state_d == ST_COUNT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      d_sync_q     <= '0;
      loadn_sync_q <= '1;
      pgt_sync_q   <= '0;
      loadn_prev_q <= 1'b1;
      pgt_prev_q   <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      state_q      <= ST_IDLE;
      min_ones_q   <= 4'd0;
      sec_tens_q   <= 4'd0;
      sec_ones_q   <= 4'd0;
      done_cnt_q   <= '0;
      cook_q       <= 1'b0;
      done_q       <= 1'b0;
      zero_q       <= 1'b1;
    end else begin
      d_sync_q     <= {d_sync_q[SYNC_STAGES-2:0], D};
      loadn_sync_q <= {loadn_sync_q[SYNC_STAGES-2:0], loadn};
      pgt_sync_q   <= {pgt_sync_q[SYNC_STAGES-2:0], pgt_1Hz};
      loadn_prev_q <= loadn_sync_q[SYNC_STAGES-1];
      pgt_prev_q   <= pgt_sync_q[SYNC_STAGES-1];
      start_q      <= start;
      stop_q       <= stop;
      state_q      <= state_d;
      min_ones_q   <= min_ones_d;
      sec_tens_q   <= sec_tens_d;
      sec_ones_q   <= sec_ones_d;
      done_cnt_q   <= done_cnt_d;
      cook_q       <= cook_d;
      done_q       <= done_d;
      zero_q       <= zero_d;
    end
  end

  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign cook     = cook_q;
  assign done     = done_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer: key entry, countdown, pause/cancel, done timeout, clear.
module tb_microwave_timer;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] D = 4'd0;
  logic       loadn = 1'b1;
  logic       pgt_1Hz = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  wire  [3:0] min_ones, sec_tens, sec_ones;
  wire        cook, done, zero;
  wire [11:0] disp = {min_ones, sec_tens, sec_ones};

  int n_checks = 0;
  int n_fail   = 0;

  microwave_timer #(.SYNC_STAGES(2), .DONE_TICKS(3)) dut (
    .clk(clk), .clear(clear), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
    .start(start), .stop(stop), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .cook(cook), .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    D = d; loadn = 1'b0; cyc(4);
    loadn = 1'b1; cyc(4);
  endtask

  task automatic tick1();
    pgt_1Hz = 1'b1; cyc(4);
    pgt_1Hz = 1'b0; cyc(4);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(2);
    start = 1'b0; cyc(1);
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(2);
    stop = 1'b0; cyc(1);
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(2);
    clear = 1'b0; cyc(1);
  endtask

  initial begin
    cyc(3);
    check_eq("rst_digits", 32'(disp), 32'h000);
    check_eq("rst_zero",   32'(zero), 32'd1);
    check_eq("rst_cook",   32'(cook), 32'd0);
    check_eq("rst_done",   32'(done), 32'd0);
    clear = 1'b0; cyc(1);

    // first key: digit must land exactly on the third edge after loadn falls
    D = 4'd1; loadn = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_eq("key_lat_early", 32'(disp), 32'h000);
    @(posedge clk); @(negedge clk);
    check_eq("key_lat_land", 32'(disp), 32'h001);
    loadn = 1'b1; cyc(3);
    press(4'd2);
    press(4'd5);
    check_eq("load_125", 32'(disp), 32'h125);
    check_eq("load_zero", 32'(zero), 32'd0);
    press(4'hC);
    check_eq("bad_digit", 32'(disp), 32'h125);

    do_clear();
    press(4'd1); press(4'd0); press(4'd0);
    pulse_start();
    check_eq("cnt_cook0", 32'(cook), 32'd1);
    tick1();
    check_eq("cnt_059", 32'(disp), 32'h059);
    check_eq("cnt_cook1", 32'(cook), 32'd1);
    tick1();
    check_eq("cnt_058", 32'(disp), 32'h058);
    check_eq("cnt_cook2", 32'(cook), 32'd1);

    do_clear();
    press(4'd2);
    pulse_start();
    tick1();
    check_eq("fin_001", 32'(disp), 32'h001);
    tick1();
    check_eq("fin_000", 32'(disp), 32'h000);
    check_eq("fin_done", 32'(done), 32'd1);
    check_eq("fin_cook", 32'(cook), 32'd0);
    check_eq("fin_zero", 32'(zero), 32'd1);
    tick1();
    check_eq("done_t1", 32'(done), 32'd1);
    tick1();
    check_eq("done_t2", 32'(done), 32'd1);
    tick1();
    check_eq("done_t3", 32'(done), 32'd0);

    do_clear();
    press(4'd9); press(4'd5);
    pulse_start();
    tick1();
    check_eq("tens95_094", 32'(disp), 32'h094);
    press(4'd7);
    check_eq("key_in_count", 32'(disp), 32'h094);
    check_eq("key_in_cook", 32'(cook), 32'd1);

    do_clear();
    press(4'd2); press(4'd0); press(4'd0);
    pulse_start();
    tick1();
    check_eq("pause_159", 32'(disp), 32'h159);
    pulse_stop();
    check_eq("pause_cook", 32'(cook), 32'd0);
    tick1(); tick1(); tick1();
    check_eq("pause_hold", 32'(disp), 32'h159);
    pulse_start();
    check_eq("resume_cook", 32'(cook), 32'd1);
    tick1();
    check_eq("resume_158", 32'(disp), 32'h158);
    pulse_stop();
    check_eq("stop1_hold", 32'(disp), 32'h158);
    pulse_stop();
    check_eq("stop2_digits", 32'(disp), 32'h000);
    check_eq("stop2_zero", 32'(zero), 32'd1);
    check_eq("stop2_cook", 32'(cook), 32'd0);

    do_clear();
    press(4'd5);
    pulse_start();
    check_eq("mid_cook", 32'(cook), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    check_eq("mid_clr_digits", 32'(disp), 32'h000);
    check_eq("mid_clr_zero", 32'(zero), 32'd1);
    check_eq("mid_clr_cook", 32'(cook), 32'd0);
    clear = 1'b0; cyc(1);

`ifdef MICROWAVE_QUICK_START_EN
    pulse_start();
    check_eq("qs_030", 32'(disp), 32'h030);
    check_eq("qs_cook", 32'(cook), 32'd1);
    pulse_start();
    check_eq("qs_100", 32'(disp), 32'h100);
    do_clear();
    press(4'd9); press(4'd4); press(4'd5);
    pulse_start();
    pulse_start();
    check_eq("qs_sat", 32'(disp), 32'h959);
`else
    pulse_start();
    check_eq("zs_digits", 32'(disp), 32'h000);
    check_eq("zs_cook", 32'(cook), 32'd0);
    press(4'd5);
    pulse_start();
    pulse_start();
    check_eq("cs_digits", 32'(disp), 32'h005);
    check_eq("cs_cook", 32'(cook), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
